simon_datapath: RTL

Datapath half of the Simon game: it consumes the strobes issued by `SimonControl` and returns the three status flags that controller branches on. It holds the difficulty level, the pattern memory, the stored-pattern count and the playback/repeat index. It also selects what the four pattern LEDs display. It sits beside `SimonControl` under the Simon top level, and its ports mirror that controller's interface one-for-one.

---
 rtl/simon_defs.sv | 25 ++
 rtl/simon_datapath_pattern_mem.sv | 27 ++
 rtl/simon_datapath.sv | 111 +++++++++++
 3 files changed

// File: rtl/simon_defs.sv
// Definitions shared by the Simon controller and datapath: default sizes,
// level encodings and LED source codes.
package simon_defs;

  localparam int PAT_W_DEF  = 4;
  localparam int ADDR_W_DEF = 6;

  localparam logic LEVEL_EASY = 1'b0;
  localparam logic LEVEL_HARD = 1'b1;

  // LED source select as driven on read_Memory by the controller
  localparam logic LED_MODE_INPUT  = 1'b0;
  localparam logic LED_MODE_MEMORY = 1'b1;

  typedef enum logic {
    LED_SRC_INPUT  = LED_MODE_INPUT,
    LED_SRC_MEMORY = LED_MODE_MEMORY
  } led_src_e;

  // True when exactly one bit of the 4-bit pattern is set
  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/simon_datapath_pattern_mem.sv
// Pattern store for the Simon datapath: synchronous write, asynchronous read.
// Write saturation is handled by the parent, which gates we.
module simon_datapath_pattern_mem #(
  parameter int PAT_W  = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PAT_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PAT_W-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [PAT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: level register, pattern memory, count/index registers
// and the status flags the controller branches on. Hard mode is compiled in
// only when SIMON_HARD_LEVEL_EN is defined.
module simon_datapath
  import simon_defs::*;
#(
  parameter int PAT_W  = PAT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             level_sw,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             set_level,
  input  logic             w_en,
  input  logic             cnt_count,
  input  logic             clr_count,
  input  logic             cnt_index,
  input  logic             clr_index,
  input  logic             read_Memory,
  output logic             is_legal,
  output logic             index_lt_count,
  output logic             input_eq_pattern,
  output logic [PAT_W-1:0] pattern_leds
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0]  count_q, count_d;
  logic [ADDR_W:0]  index_q, index_d;
  logic             level_q;
  logic [PAT_W-1:0] rd;
  logic             mem_we;
  logic             one_hot;

`ifdef SIMON_HARD_LEVEL_EN
  logic level_d;

  always_comb begin
    level_d = level_q;
    if (set_level) begin
      level_d = level_sw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= LEVEL_EASY;
    end else begin
      level_q <= level_d;
    end
  end
`else
  logic unused_level;

  assign level_q      = LEVEL_EASY;
  assign unused_level = set_level ^ level_sw;
`endif

  // Clear beats increment; both counters stop at DEPTH rather than wrapping
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (cnt_count && (count_q != FULL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    index_d = index_q;
    if (clr_index) begin
      index_d = '0;
    end else if (cnt_index && (index_q != FULL)) begin
      index_d = index_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      index_q <= '0;
    end else begin
      count_q <= count_d;
      index_q <= index_d;
    end
  end

  assign mem_we = w_en && (count_q != FULL);

  simon_datapath_pattern_mem #(
    .PAT_W (PAT_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(count_q[ADDR_W-1:0]),
    .wdata(pattern_in),
    .raddr(index_q[ADDR_W-1:0]),
    .rdata(rd)
  );

  assign one_hot = (pattern_in != '0) && ((pattern_in & (pattern_in - 1'b1)) == '0);

  assign is_legal         = (level_q == LEVEL_HARD) || one_hot;
  assign index_lt_count   = index_q < count_q;
  assign input_eq_pattern = (pattern_in == rd);
  assign pattern_leds     = (read_Memory == LED_MODE_MEMORY) ? rd : pattern_in;

endmodule
